// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and helpers for the sequential RV32IM divider
package div_pkg;

    // Widest operand div_abs can take; instantiations keep WIDTH at or below this.
    localparam int DIV_MAX_W = 64;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DIVIDE = 2'b01,
        DONE   = 2'b10
    } div_state_e;

    // x must arrive sign-extended to DIV_MAX_W when is_signed is set.
    // The low bits of the result are the magnitude at any narrower width.
    function automatic logic [DIV_MAX_W-1:0] div_abs(
        input logic [DIV_MAX_W-1:0] x,
        input logic                 is_signed
    );
        logic [DIV_MAX_W-1:0] r;
        r = x;
        if (is_signed && x[DIV_MAX_W-1]) begin
            r = (~x) + DIV_MAX_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    // Shift {A,Q} left and try subtracting |b|. A < |b| on entry, so the
    // shifted A is below 2|b| and the trial fits WIDTH+1 bits with its sign in the MSB.
    always_comb begin
        rem_sh = {rem_i, quo_i[WIDTH-1]};
        trial  = rem_sh - {1'b0, divisor_i};
        if (trial[WIDTH]) begin
            rem_o = rem_sh[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end else begin
            rem_o = trial[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq_unit.sv
// rtl/div_seq_unit.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
module div_seq_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_div,
    input  logic [1:0]       fuct3,
    input  logic [WIDTH-1:0] oper_a,
    input  logic [WIDTH-1:0] oper_b,
    input  logic             flush,
    output logic             busy,
    output logic             div_finish,
    output logic [WIDTH-1:0] div_o,
    output logic             divided_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] babs_q, babs_d;
    div_op_e          op_q, op_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] div_o_q, div_o_d;
    logic             dbz_q, dbz_d;

    logic                    in_signed;
    logic                    in_rem;
    logic                    in_overflow;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]        a_abs;
    logic [WIDTH-1:0]        b_abs;
    logic [WIDTH-1:0]        step_a;
    logic [WIDTH-1:0]        step_q;
    logic [WIDTH-1:0]        result;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i     (a_q),
        .quo_i     (q_q),
        .divisor_i (babs_q),
        .rem_o     (step_a),
        .quo_o     (step_q)
    );

    // Decode the incoming request and form operand magnitudes.
    always_comb begin
        in_signed   = ~fuct3[0];
        in_rem      = fuct3[1];
        a_s         = oper_a;
        b_s         = oper_b;
        a_abs       = WIDTH'(div_abs(DIV_MAX_W'(a_s), in_signed));
        b_abs       = WIDTH'(div_abs(DIV_MAX_W'(b_s), in_signed));
        in_overflow = in_signed && (oper_a == MIN_NEG) && (oper_b == '1);
    end

    // Sign fix-up of the final iteration's quotient/remainder.
    always_comb begin
        result = step_a;
        case (op_q)
            OP_DIV:  result = (sign_a_q ^ sign_b_q) ? -step_q : step_q;
            OP_REM:  result = sign_a_q ? -step_a : step_a;
            OP_DIVU: result = step_q;
            default: result = step_a;
        endcase
    end

    // Next-state logic: accept, iterate, finish, flush.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        q_d      = q_q;
        babs_d   = babs_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        div_o_d  = div_o_q;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE: begin
                if (enable_div && !flush) begin
                    op_d     = div_op_e'(fuct3);
                    sign_a_d = in_signed & oper_a[WIDTH-1];
                    sign_b_d = in_signed & oper_b[WIDTH-1];
                    a_d      = '0;
                    q_d      = a_abs;
                    babs_d   = b_abs;
                    cnt_d    = CNT_W'(WIDTH);
                    if (oper_b == '0) begin
                        state_d = DONE;
                        div_o_d = in_rem ? oper_a : '1;
                        dbz_d   = 1'b1;
                    end else if (in_overflow) begin
                        state_d = DONE;
                        div_o_d = in_rem ? '0 : oper_a;
                        dbz_d   = 1'b0;
                    end else begin
                        state_d = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    a_d   = step_a;
                    q_d   = step_q;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                        div_o_d = result;
                        dbz_d   = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            q_q      <= '0;
            babs_q   <= '0;
            op_q     <= OP_DIV;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            div_o_q  <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            q_q      <= q_d;
            babs_q   <= babs_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            div_o_q  <= div_o_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy            = (state_q == DIVIDE);
    assign div_finish      = (state_q == DONE);
    assign div_o           = div_o_q;
    assign divided_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// tb/tb_div_seq_unit.sv - scoreboard bench for div_seq_unit
module tb_div_seq_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable_div = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   fuct3 = 2'b00;
    logic [W-1:0] oper_a = '0;
    logic [W-1:0] oper_b = '0;
    logic         busy;
    logic         div_finish;
    logic [W-1:0] div_o;
    logic         divided_by_zero;

    div_seq_unit #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_div      (enable_div),
        .fuct3           (fuct3),
        .oper_a          (oper_a),
        .oper_b          (oper_b),
        .flush           (flush),
        .busy            (busy),
        .div_finish      (div_finish),
        .div_o           (div_o),
        .divided_by_zero (divided_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        logic        dbz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          n_exp = 0;
    logic [31:0] last_exp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Reference: RISC-V M-extension semantics written with plain arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sa;
        int   sb_;
        sa    = a;
        sb_   = b;
        e.dbz = 1'b0;
        e.lat = 33;
        e.acc = 0;
        if (b == 0) begin
            e.dbz = 1'b1;
            e.lat = 1;
            e.val = op[1] ? a : 32'hFFFF_FFFF;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lat = 1;
            e.val = op[1] ? 32'h0 : a;
        end else begin
            case (op)
                2'b00:   e.val = sa / sb_;
                2'b01:   e.val = a / b;
                2'b10:   e.val = sa % sb_;
                default: e.val = a % b;
            endcase
        end
        return e;
    endfunction

    // Monitor: pop and compare on every result pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && div_finish) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_finish actual=1 required=0");
            end else begin
                e = sb.pop_front();
                check("div_o", div_o, e.val);
                check("divided_by_zero", divided_by_zero, e.dbz);
                check("latency", cyc - e.acc + 1, e.lat);
                check("busy_in_done", busy, 0);
                last_exp = e.val;
                done_cnt++;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit track);
        exp_t e;
        @(negedge clk);
        enable_div = 1'b1;
        fuct3      = op;
        oper_a     = a;
        oper_b     = b;
        e          = model(op, a, b);
        if (track) begin
            e.acc = cyc + 1;
            sb.push_back(e);
            n_exp++;
        end
        @(negedge clk);
        enable_div = 1'b0;
        fuct3      = 2'($urandom);
        oper_a     = $urandom;
        oper_b     = $urandom;
        if (track) check("busy_after_accept", busy, (e.lat == 33));
    endtask

    task automatic wait_done();
        for (int t = 0; t < 200 && done_cnt < n_exp; t++) @(negedge clk);
        checks++;
        if (done_cnt < n_exp) begin
            errors++;
            $display("FAIL timeout actual=%0d required=%0d", done_cnt, n_exp);
            done_cnt = n_exp;
            sb.delete();
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(0, 20));
            4:       v = -32'($urandom_range(1, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_finish", div_finish, 0);
        check("reset_div_o", div_o, 0);
        check("reset_dbz", divided_by_zero, 0);
        rst_n = 1'b1;

        issue(2'b00, 32'd7, -32'sd2, 1'b1);         wait_done();
        issue(2'b10, 32'd7, -32'sd2, 1'b1);         wait_done();
        issue(2'b10, -32'sd7, 32'd2, 1'b1);         wait_done();
        issue(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b1);   wait_done();
        issue(2'b11, 32'hFFFF_FFFF, 32'd2, 1'b1);   wait_done();
        issue(2'b00, 32'h1234, 32'd0, 1'b1);        wait_done();
        issue(2'b11, 32'h1234, 32'd0, 1'b1);        wait_done();
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_done();
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_done();

        // Request while busy must be dropped, not queued.
        issue(2'b00, 32'd7, -32'sd2, 1'b1);
        repeat (3) @(negedge clk);
        enable_div = 1'b1;
        fuct3      = 2'b00;
        oper_b     = 32'd0;
        @(negedge clk);
        enable_div = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);

        // Flush together with a start request in IDLE: nothing accepted.
        @(negedge clk);
        enable_div = 1'b1;
        flush      = 1'b1;
        fuct3      = 2'b01;
        oper_a     = 32'd50;
        oper_b     = 32'd5;
        @(negedge clk);
        enable_div = 1'b0;
        flush      = 1'b0;
        check("flush_wins_idle", busy, 0);

        // Flush part-way through an operation.
        issue(2'b00, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_drop", busy, 0);
        check("flush_div_o_hold", div_o, last_exp);
        repeat (40) @(negedge clk);
        issue(2'b00, 32'd100, 32'd7, 1'b1);
        wait_done();
        check("after_flush_result", last_exp, 32'd14);

        // Asynchronous reset mid-operation.
        issue(2'b01, 32'd5000, 32'd9, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_finish", div_finish, 0);
        check("midreset_div_o", div_o, 0);
        check("midreset_dbz", divided_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            issue(2'($urandom), pick(), pick(), 1'b1);
            wait_done();
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
